complex_accumulator: RTL and testbench
======================================

Name: complex_accumulator

Overview:
- Downstream consumer of the complex multiplier's 64-bit products (pr, pi).
- Accumulates a frame of LEN complex products, or fewer if in_last is asserted, into wide signed real and imaginary sums.
- Presents each frame sum through a registered valid/ready output for a downstream correlator or FIR stage.
- Products are treated as two's-complement signed values.

Parameters:
- IN_W, 64, width of each incoming product component (pr, pi)
- ACC_W, 72, accumulator/output width; must satisfy ACC_W >= IN_W
- LEN, 16, maximum products per frame; must satisfy LEN >= 1
- CNT_W, 8, width of frame_cnt

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product pair valid
- in_ready  output  1  block can accept a product this cycle
- pr  input  IN_W  real product, signed
- pi  input  IN_W  imaginary product, signed
- in_last  input  1  closes the frame early on this product
- out_valid  output  1  frame sum valid
- out_ready  input  1  downstream accepts the frame sum
- acc_re  output  ACC_W  real frame sum
- acc_im  output  ACC_W  imaginary frame sum
- acc_ovf  output  1  an overflow occurred anywhere in this frame (re or im)
- frame_cnt  output  CNT_W  number of frames delivered, wraps at 2^CNT_W

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Internal sums, sample counter, acc_re, acc_im, acc_ovf, out_valid and frame_cnt all go to 0.
  - in_ready reads 1 once reset is released; it is combinational from registered state.
- in_ready = !out_valid || out_ready.
  - Depends only on registered out_valid and on out_ready; never on in_valid or in_last.
- Accept: in_valid && in_ready at a rising edge.
  - pr and pi are sign-extended to ACC_W and added to the running sums.
  - The sample counter increments.
- Frame end: an accepted sample with in_last=1, or the accepted sample with count == LEN-1.
  - On the same edge:
    - acc_re/acc_im load (running sum + current sample).
    - acc_ovf loads the frame's sticky overflow OR this add's overflow.
    - out_valid is set.
    - The running sums, sticky overflow and counter clear to 0.
  - Latency: the sum is visible one cycle after the last sample is accepted.
  - Full throughput: with out_ready held high, back-to-back frames have no bubble.
- Output handshake: out_valid && out_ready at an edge.
  - out_valid clears, unless a new frame end occurs on the same edge, in which case it stays 1 with the new sum.
  - frame_cnt increments and wraps to 0 after 2^CNT_W-1.
- Stall: while out_valid=1 and out_ready=0:
  - in_ready=0.
  - acc_re, acc_im and acc_ovf hold stable.
  - No input is consumed.
- in_last on a non-accepted cycle is ignored.
- in_last together with count == LEN-1 is a single frame end.
- LEN=1: every accepted sample is a frame.
- Overflow detection, per component: both addends have the same sign and the sum's sign differs. The overflow is recorded in the sticky bit.
- Default arithmetic: modulo 2^ACC_W wrap.
- Reset mid-frame: the partial sum is discarded and no out_valid is produced for it.

Optional Feature:
- Macro: COMPLEX_ACC_SAT_EN.
- Defined: each component add saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow. Saturation is applied per add and accumulation continues from the saturated value. acc_ovf is still reported.
- Undefined: sums wrap modulo 2^ACC_W; acc_ovf is still reported.

Test Plan:
- Basic frame: LEN=4, out_ready=1; feed (pr=2247, pi=3599) on 4 consecutive cycles -> one cycle after the 4th accept, out_valid=1, acc_re=8988, acc_im=14396, acc_ovf=0, frame_cnt goes 0->1 on that handshake.
- Signed / early last: LEN=16; feed (pr=-5, pi=10), (pr=3, pi=-20), then (pr=-1, pi=0) with in_last=1 -> acc_re=-3, acc_im=-10. The next frame starts from 0.
- Backpressure: out_ready=0 after the first frame completes -> out_valid and the sums hold, in_ready=0, and 3 cycles of offered input are not consumed. Raise out_ready -> that same cycle in_ready=1 and the next frame accumulates correctly.
- Back-to-back: LEN=2, out_ready=1, 6 consecutive samples of (1,1) -> three frames of (2,2) with no idle cycle, frame_cnt=3.
- Overflow: ACC_W=64, LEN=2; feed pr=0x7FFFFFFFFFFFFFFF then pr=1.
  - Without the macro: acc_re=0x8000000000000000, acc_ovf=1.
  - With COMPLEX_ACC_SAT_EN: acc_re=0x7FFFFFFFFFFFFFFF, acc_ovf=1.
- Reset mid-frame: LEN=4; accept 2 samples, then pulse rst_n low asynchronously between clock edges -> all outputs go to 0 immediately. Feeding 4 samples of (1,1) afterwards yields exactly (4,4).

Source files
------------

// File: rtl/complex_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : complex_accumulator
// Description : Accumulates frames of up to LEN signed complex products
//               (pr, pi) into ACC_W-bit real/imaginary sums.  A frame closes
//               on in_last or on its LEN-th sample.  Each frame sum is
//               presented on a registered valid/ready output together with a
//               sticky overflow flag.  A running count of delivered frames is
//               also kept.
//               Optional macro COMPLEX_ACC_SAT_EN: each component add
//               saturates instead of wrapping modulo 2^ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module complex_accumulator #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 72,
    parameter int LEN   = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  pr,
    input  logic [IN_W-1:0]  pi,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_re,
    output logic [ACC_W-1:0] acc_im,
    output logic             acc_ovf,
    output logic [CNT_W-1:0] frame_cnt
);

    // Sample counter only needs to reach LEN-1; keep at least one bit.
    localparam int                    c_SCNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_SCNT_W-1:0]   c_LAST   = c_SCNT_W'(LEN - 1);

`ifdef COMPLEX_ACC_SAT_EN
    localparam logic [ACC_W-1:0]      c_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]      c_MIN    = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [ACC_W-1:0]    r_sum_re;
    logic [ACC_W-1:0]    r_sum_im;
    logic                r_sticky;
    logic [c_SCNT_W-1:0] r_cnt;

    logic [ACC_W-1:0]    w_re_ext;
    logic [ACC_W-1:0]    w_im_ext;
    logic [ACC_W-1:0]    w_raw_re;
    logic [ACC_W-1:0]    w_raw_im;
    logic                w_ovf_re;
    logic                w_ovf_im;
    logic [ACC_W-1:0]    w_next_re;
    logic [ACC_W-1:0]    w_next_im;
    logic                w_accept;
    logic                w_frame_end;
    logic                w_out_hs;

    // Sign-extend the products to accumulator width.
    generate
        if (ACC_W > IN_W) begin : g_sext
            assign w_re_ext = {{(ACC_W-IN_W){pr[IN_W-1]}}, pr};
            assign w_im_ext = {{(ACC_W-IN_W){pi[IN_W-1]}}, pi};
        end else begin : g_direct
            assign w_re_ext = pr;
            assign w_im_ext = pi;
        end
    endgenerate

    // Handshake decode: input side is free whenever the output slot drains.
    assign in_ready    = !out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_frame_end = w_accept && (in_last || (r_cnt == c_LAST));
    assign w_out_hs    = out_valid && out_ready;

    // Two's-complement add; overflow when both addends agree in sign and
    // the result does not.
    assign w_raw_re = r_sum_re + w_re_ext;
    assign w_raw_im = r_sum_im + w_im_ext;
    assign w_ovf_re = (r_sum_re[ACC_W-1] == w_re_ext[ACC_W-1]) &&
                      (w_raw_re[ACC_W-1] != r_sum_re[ACC_W-1]);
    assign w_ovf_im = (r_sum_im[ACC_W-1] == w_im_ext[ACC_W-1]) &&
                      (w_raw_im[ACC_W-1] != r_sum_im[ACC_W-1]);

`ifdef COMPLEX_ACC_SAT_EN
    // On overflow clamp towards the sign of the running sum.
    assign w_next_re = w_ovf_re ? (r_sum_re[ACC_W-1] ? c_MIN : c_MAX) : w_raw_re;
    assign w_next_im = w_ovf_im ? (r_sum_im[ACC_W-1] ? c_MIN : c_MAX) : w_raw_im;
`else
    assign w_next_re = w_raw_re;
    assign w_next_im = w_raw_im;
`endif

    // Running sums, sticky overflow and sample counter; cleared at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_re <= '0;
            r_sum_im <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_frame_end) begin
            r_sum_re <= '0;
            r_sum_im <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_sum_re <= w_next_re;
            r_sum_im <= w_next_im;
            r_sticky <= r_sticky | w_ovf_re | w_ovf_im;
            r_cnt    <= r_cnt + c_SCNT_W'(1);
        end
    end

    // Output slot: loads at frame end, empties on handshake, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re    <= '0;
            acc_im    <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (w_frame_end) begin
            acc_re    <= w_next_re;
            acc_im    <= w_next_im;
            acc_ovf   <= r_sticky | w_ovf_re | w_ovf_im;
            out_valid <= 1'b1;
        end else if (w_out_hs) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-frame counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (w_out_hs) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_complex_accumulator
// Description : Self-checking bench for complex_accumulator.  Two instances
//               share one stimulus stream: A (ACC_W=72, LEN=4, CNT_W=8) and
//               B (ACC_W=64, LEN=2, CNT_W=2).  An arithmetic frame model per
//               instance is compared every cycle, plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complex_accumulator;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [63:0] pr;
    logic signed [63:0] pi;
    logic               in_last;
    logic               out_ready;

    logic        in_ready_a, out_valid_a, acc_ovf_a;
    logic [71:0] acc_re_a, acc_im_a;
    logic [7:0]  frame_cnt_a;
    logic        in_ready_b, out_valid_b, acc_ovf_b;
    logic [63:0] acc_re_b, acc_im_b;
    logic [1:0]  frame_cnt_b;

    int n_cmp;
    int n_bad;

    complex_accumulator #(.IN_W(64), .ACC_W(72), .LEN(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .pr(pr), .pi(pi), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .acc_re(acc_re_a), .acc_im(acc_im_a),
        .acc_ovf(acc_ovf_a), .frame_cnt(frame_cnt_a)
    );

    complex_accumulator #(.IN_W(64), .ACC_W(64), .LEN(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .pr(pr), .pi(pi), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .acc_re(acc_re_b), .acc_im(acc_im_b),
        .acc_ovf(acc_ovf_b), .frame_cnt(frame_cnt_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural frame model ----------------
    int c_len [2] = '{4, 2};
    int c_w   [2] = '{72, 64};
    int c_cw  [2] = '{8, 2};

    logic signed [127:0] m_sre [2];
    logic signed [127:0] m_sim [2];
    logic signed [127:0] m_re  [2];
    logic signed [127:0] m_im  [2];
    int                  m_cnt [2];
    bit                  m_stk [2];
    bit                  m_ovf [2];
    bit                  m_ov  [2];
    int                  m_fc  [2];

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_sre[i] = 0; m_sim[i] = 0; m_re[i] = 0; m_im[i] = 0;
            m_cnt[i] = 0; m_stk[i] = 0; m_ovf[i] = 0; m_ov[i] = 0; m_fc[i] = 0;
        end
    endtask

    // Mathematical add of two in-range w-bit values, then range fix-up.
    task automatic madd(input logic signed [127:0] a, input logic signed [127:0] b,
                        input int w, output logic signed [127:0] r, output bit ov);
        logic signed [127:0] s, mx, mn, span;
        s    = a + b;
        span = 128'sd1 <<< w;
        mx   = (128'sd1 <<< (w - 1)) - 1;
        mn   = -(128'sd1 <<< (w - 1));
        ov   = (s > mx) || (s < mn);
`ifdef COMPLEX_ACC_SAT_EN
        r = (s > mx) ? mx : ((s < mn) ? mn : s);
`else
        r = (s > mx) ? s - span : ((s < mn) ? s + span : s);
`endif
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                bit acc, hs, fend, ovr, ovi;
                logic signed [127:0] nr, ni, xr, xi;
                acc  = in_valid && (!m_ov[i] || out_ready);
                hs   = m_ov[i] && out_ready;
                fend = acc && (in_last || (m_cnt[i] == c_len[i] - 1));
                xr = pr;
                xi = pi;
                if (hs) m_fc[i] = (m_fc[i] + 1) % (1 << c_cw[i]);
                if (acc) begin
                    madd(m_sre[i], xr, c_w[i], nr, ovr);
                    madd(m_sim[i], xi, c_w[i], ni, ovi);
                    if (fend) begin
                        m_re[i]  = nr;
                        m_im[i]  = ni;
                        m_ovf[i] = m_stk[i] | ovr | ovi;
                        m_sre[i] = 0; m_sim[i] = 0; m_stk[i] = 0; m_cnt[i] = 0;
                    end else begin
                        m_sre[i] = nr; m_sim[i] = ni;
                        m_stk[i] = m_stk[i] | ovr | ovi;
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (fend)    m_ov[i] = 1;
                else if (hs) m_ov[i] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [71:0] er_a, ei_a;
        logic [63:0] er_b, ei_b;
        er_a = m_re[0][71:0]; ei_a = m_im[0][71:0];
        er_b = m_re[1][63:0]; ei_b = m_im[1][63:0];
        chk("a.in_ready",  in_ready_a,  !m_ov[0] || out_ready);
        chk("a.out_valid", out_valid_a, m_ov[0]);
        chk("a.acc_re",    acc_re_a,    er_a);
        chk("a.acc_im",    acc_im_a,    ei_a);
        chk("a.acc_ovf",   acc_ovf_a,   m_ovf[0]);
        chk("a.frame_cnt", frame_cnt_a, m_fc[0]);
        chk("b.in_ready",  in_ready_b,  !m_ov[1] || out_ready);
        chk("b.out_valid", out_valid_b, m_ov[1]);
        chk("b.acc_re",    acc_re_b,    er_b);
        chk("b.acc_im",    acc_im_b,    ei_b);
        chk("b.acc_ovf",   acc_ovf_b,   m_ovf[1]);
        chk("b.frame_cnt", frame_cnt_b, m_fc[1]);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic signed [63:0] r, input logic signed [63:0] i,
                         input bit l, input bit ordy);
        in_valid = v; pr = r; pi = i; in_last = l; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic call(input bit v, input logic signed [63:0] r, input logic signed [63:0] i,
                        input bit l, input bit ordy);
        drive(v, r, i, l, ordy);
        tick();
    endtask

    task automatic pulse_reset();
        #1 rst_n = 0;
        mreset();
        #1;
        chk("rst.a.out_valid", out_valid_a, 0);
        chk("rst.a.acc_re",    acc_re_a,    0);
        chk("rst.a.frame_cnt", frame_cnt_a, 0);
        chk("rst.b.acc_re",    acc_re_b,    0);
        rst_n = 1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        clk = 0; rst_n = 0;
        drive(0, 0, 0, 0, 1);
        mreset();
        #12 rst_n = 1;
        #1;
        chk("reset.in_ready",  in_ready_a,  1);
        chk("reset.out_valid", out_valid_a, 0);
        chk("reset.acc_re",    acc_re_a,    0);
        chk("reset.frame_cnt", frame_cnt_a, 0);

        // Basic frame of four identical products.
        for (int k = 0; k < 4; k++) call(1, 2247, 3599, 0, 1);
        chk("basic.out_valid", out_valid_a, 1);
        chk("basic.acc_re",    acc_re_a,    8988);
        chk("basic.acc_im",    acc_im_a,    14396);
        chk("basic.acc_ovf",   acc_ovf_a,   0);
        chk("basic.cnt_pre",   frame_cnt_a, 0);
        call(0, 0, 0, 0, 1);
        chk("basic.cnt_post",  frame_cnt_a, 1);

        // Signed values with an early in_last.
        call(1, -5, 10, 0, 1);
        call(1, 3, -20, 0, 1);
        call(1, -1, 0, 1, 1);
        chk("signed.acc_re", $signed(acc_re_a), -3);
        chk("signed.acc_im", $signed(acc_im_a), -10);
        call(0, 0, 0, 0, 1);

        // Backpressure: frame completes, then the output is held.
        for (int k = 0; k < 4; k++) call(1, 7, 8, 0, 0);
        chk("bp.out_valid", out_valid_a, 1);
        chk("bp.acc_re",    acc_re_a,    28);
        for (int k = 0; k < 3; k++) begin
            call(1, 100, 100, 0, 0);
            chk("bp.in_ready_stall", in_ready_a, 0);
            chk("bp.acc_hold",       acc_re_a,   28);
        end
        drive(1, 5, 5, 0, 1);
        #1;
        chk("bp.in_ready_release", in_ready_a, 1);
        tick();
        for (int k = 0; k < 3; k++) call(1, 5, 5, 0, 1);
        chk("bp.next_re", acc_re_a, 20);
        chk("bp.next_im", acc_im_a, 20);
        call(0, 0, 0, 0, 1);

        // Reset in the middle of a frame discards the partial sum.
        call(1, 9, 9, 0, 1);
        call(1, 9, 9, 0, 1);
        pulse_reset();
        for (int k = 0; k < 4; k++) call(1, 1, 1, 0, 1);
        chk("rstmid.out_valid", out_valid_a, 1);
        chk("rstmid.acc_re",    acc_re_a,    4);
        chk("rstmid.acc_im",    acc_im_a,    4);

        // Overflow on the 64-bit instance.
        call(1, 64'sh7FFF_FFFF_FFFF_FFFF, 0, 0, 1);
        call(1, 1, 0, 0, 1);
`ifdef COMPLEX_ACC_SAT_EN
        chk("ovf.acc_re", acc_re_b, 64'h7FFF_FFFF_FFFF_FFFF);
`else
        chk("ovf.acc_re", acc_re_b, 64'h8000_0000_0000_0000);
`endif
        chk("ovf.acc_ovf", acc_ovf_b, 1);

        // Back-to-back LEN=2 frames on instance B from a clean state.
        pulse_reset();
        for (int k = 1; k <= 6; k++) begin
            call(1, 1, 1, 0, 1);
            chk("b2b.in_ready", in_ready_b, 1);
            if (k % 2 == 0) chk("b2b.acc_re", acc_re_b, 2);
        end
        call(0, 0, 0, 0, 1);
        chk("b2b.frame_cnt", frame_cnt_b, 3);

        // Randomized traffic including extreme magnitudes.
        for (int k = 0; k < 3000; k++) begin
            logic signed [63:0] rv [2];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 3))
                    0: rv[j] = $signed(64'($urandom_range(0, 200))) - 100;
                    1: rv[j] = {$urandom, $urandom};
                    2: rv[j] = 64'sh7FFF_FFFF_FFFF_FFFF - $signed(64'($urandom_range(0, 15)));
                    default: rv[j] = 64'sh8000_0000_0000_0000 + $signed(64'($urandom_range(0, 15)));
                endcase
            end
            call($urandom_range(0, 3) != 0, rv[0], rv[1],
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
